// File: rtl/cla_nibble_serial_adder.sv
// Nibble-serial adder: one 4-bit carry look-ahead slice is reused over NIB clocks,
// least-significant nibble first, with valid/ready handshakes on both sides.
module cla_nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             busy_o
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [KW-1:0] LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic             carry_q, carry_d;
  logic [KW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [KW+1:0]    nibBase;
  logic [3:0]       aNib, bNib, g, p, sNib;
  logic [4:0]       c;
  logic             accept;

  assign nibBase = {idx_q, 2'b00};
  assign aNib    = opA_q[nibBase +: 4];
  assign bNib    = opB_q[nibBase +: 4];
  assign g       = aNib & bNib;
  assign p       = aNib ^ bNib;

  // Look-ahead carries for the current slice, seeded by the inter-nibble carry register.
  assign c[0] = carry_q;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign sNib = p ^ c[3:0];

  assign in_ready_o  = (state_q == IDLE) && !rst;
  assign out_valid_o = (state_q == DONE);
  assign busy_o      = (state_q == RUN) || (state_q == DONE);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;
  assign accept      = in_valid_i && in_ready_o;

  always_comb begin
    state_d = state_q;
    opA_d   = opA_q;
    opB_d   = opB_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          opA_d   = a_i;
          opB_d   = b_i;
          carry_d = cin_i;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[nibBase +: 4] = sNib;
        carry_d             = c[4];
        // The index stops at the last slice; it is only rewound by accept or reset.
        if (idx_q == LAST) begin
          cout_d  = c[4];
          ovf_d   = c[3] ^ c[4];
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Scoreboard bench for cla_nibble_serial_adder: the driver queues hand-computed
// results, a monitor pops and compares them on every output handshake.
module tb_cla_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } result_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             cin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  result_t expQ[$];

  cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .b_i(b), .cin_i(cin),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .sum_o(sum), .cout_o(cout), .ovf_o(ovf), .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result is compared against the head of the scoreboard.
  initial begin
    result_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_result", 32'(out_valid), 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("sum", 32'(sum), 32'(e.sum));
          checkOutput("cout", 32'(cout), 32'(e.cout));
          checkOutput("ovf", 32'(ovf), 32'(e.ovf));
        end
        doneCount++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  // Drive one operation; optionally measures accept-to-valid latency and waits for the handshake.
  task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                               input logic vcin, input logic [WIDTH-1:0] eSum,
                               input logic eCout, input logic eOvf, input bit waitDone);
    int cyc;
    int startDone;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
    a = va; b = vb; cin = vcin; in_valid = 1'b1;
    expQ.push_back('{sum: eSum, cout: eCout, ovf: eOvf});
    startDone = doneCount;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (waitDone) begin
      cyc = 0;
      while (!out_valid && cyc < 50) begin
        @(posedge clk); #1; cyc++;
      end
      checkOutput("latency", 32'(cyc), 32'(NIB));
      cyc = 0;
      while (doneCount == startDone && cyc < 50) begin
        @(posedge clk); #1; cyc++;
      end
      checkOutput("handshake_seen", 32'(doneCount - startDone), 32'd1);
    end
  endtask

  initial begin
    result_t hold;
    int cyc;
    $display("[TB] starting");
    #12;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_sum", 32'({sum, cout, ovf}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

    applyStimulus(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    applyStimulus(16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b1);

    // Operand change one cycle after accept must not affect the result.
    applyStimulus(16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
    a = 16'hAAAA;
    cyc = 0;
    while (expQ.size() != 0 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    checkOutput("latched_done", 32'(expQ.size()), 32'd0);

    // Backpressure: DONE is held with stable outputs while out_ready is low.
    out_ready = 1'b0;
    applyStimulus(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_sum", 32'(sum), 32'h1000);
      checkOutput("bp_flags", 32'({cout, ovf}), 32'd0);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
    checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset two cycles into an operation aborts it with no output.
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    a = 16'h3333; b = 16'h4444; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready), 32'd0);
    checkOutput("abort_outputs", 32'({sum, cout, ovf}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    applyStimulus(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);

    repeat (10) @(posedge clk);
    #1;
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
